// File: rtl/rv32_pkg.sv
// rv32_pkg -- shared RV32 fetch-path definitions.
// Holds the instruction width, the canonical NOP encoding, the default reset
// PC, the fetch FSM state type and the 64-bit instruction-buffer entry.
package rv32_pkg;

  localparam int              ILEN             = 32;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013; // addi x0,x0,0
  localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // One buffered instruction: word plus the PC it was fetched from (64 bits).
  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [ILEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- instruction buffer between instruction memory and decode.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, data_i   write one {inst, pc} entry
//   pop_i            drop the head entry
//   flush_i          empty the buffer (wins over push/pop)
//   data_o           head entry (meaningful when !empty_o)
//   full_o, empty_o  occupancy flags
//   count_o          current occupancy
// Only DEPTH=2 is supported; pointers are 1 bit and wrap naturally.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Push and pop in the same cycle are independent, so a full buffer can
  // accept a new entry while its head leaves and stays at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetch with redirect and a 2-entry
// instruction buffer.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req, imem_addr       read request / word address to instruction memory
//   imem_rdata                read data, one cycle after an issued request
//   redirect_valid/_pc        branch/jump redirect (pc bits [1:0] ignored)
//   inst, inst_pc, inst_valid instruction to decode (NOP/0 when not valid)
//   inst_ready                decode accepts the presented instruction
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [ILEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [ILEN-1:0] redirect_pc,
  output logic [ILEN-1:0] inst,
  output logic [ILEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [ILEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] infl_pc_q, infl_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    head, push_entry;
  logic            pop, push, issue;
  logic [CW:0]     credit_used;

  // Buffer slots committed after this cycle: current occupancy plus the
  // response in flight, minus the head leaving now. Counting the pop lets a
  // new request go out every cycle while decode keeps up.
  assign pop         = inst_valid && inst_ready;
  assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    infl_pc_d  = infl_pc_q;
    issue      = 1'b0;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    issue = (state_q == RUN) && !rst && !redirect_valid &&
            (credit_used < (CW+1)'(FIFO_DEPTH));

    if (redirect_valid) begin
      pc_d = {redirect_pc[ILEN-1:2], 2'b00};
    end else if (issue) begin
      pc_d       = pc_q + 32'd4;
      inflight_d = 1'b1;
      infl_pc_d  = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      infl_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      infl_pc_q  <= infl_pc_d;
    end
  end

  // A returning response is dropped on redirect; after a reset edge
  // inflight_q is clear, so a stale response is ignored as well.
  assign push            = inflight_q && !redirect_valid && !rst;
  assign push_entry.inst = imem_rdata;
  assign push_entry.pc   = infl_pc_q;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop && !redirect_valid),
    .flush_i (redirect_valid),
    .data_i  (push_entry),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign imem_req   = issue;
  assign imem_addr  = pc_q;
  assign inst_valid = !fifo_empty && !rst;
  assign inst       = inst_valid ? head.inst : NOP;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  logic unused_ok;
  assign unused_ok = ^{redirect_pc[1:0], fifo_full};

endmodule
